mem_stage: RTL and testbench

- Memory-access pipeline stage. It consumes the 80-bit EX result bundle (`EX_DATA`) and performs loads and stores over a valid/grant/rvalid data-memory interface.
- It aligns and extends load data and delivers a 74-bit bundle (`MEM_DATA`) to write-back through a valid/ready handshake.
- It holds its own EX/MEM register and drives forwarding and stall signals for the hazard unit.

---
 rtl/mem_stage_pkg.sv | 48 ++++
 rtl/mem_align.sv | 43 ++++
 rtl/mem_stage.sv | 132 +++++++++++++
 tb/tb_mem_stage.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, field layouts, access-size codes and stage states for the memory stage.
// The misalign rule lives here so the stage can classify an incoming bundle before latching it.
package mem_stage_pkg;

    localparam int EX_DATA_W  = 80;
    localparam int MEM_DATA_W = 74;

    localparam logic [2:0] MM_BYTE = 3'b000;
    localparam logic [2:0] MM_HALF = 3'b001;
    localparam logic [2:0] MM_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic        mem_write;
        logic        mem_read;
        logic        reg_write;
        logic [3:0]  memto_reg;
        logic [2:0]  mem_mode;
        logic        mem_read_us;
        logic [31:0] rdata2;
        logic [4:0]  rd;
        logic [31:0] result;
    } ex_data_t;

    typedef struct packed {
        logic        reg_write;
        logic [3:0]  memto_reg;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] load_data;
    } mem_data_t;

    // Unknown size codes behave as word accesses.
    function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] off);
        case (mode)
            MM_BYTE: return 1'b0;
            MM_HALF: return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store strobes/replicated data, load byte/half select and extend,
// and the misalignment flag for the access described by mode_i/off_i.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  mode_i,
    input  logic [1:0]  off_i,
    input  logic        read_us_i,
    input  logic [31:0] rdata2_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_o,
    output logic        misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel   = rdata_i[{off_i, 3'b000} +: 8];
    assign half_sel   = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    assign misalign_o = is_misaligned(mode_i, off_i);

    always_comb begin
        wstrb_o = 4'b1111;
        wdata_o = rdata2_i;
        load_o  = rdata_i;
        case (mode_i)
            MM_BYTE: begin
                wstrb_o = 4'b0001 << off_i;
                wdata_o = {4{rdata2_i[7:0]}};
                load_o  = {{24{~read_us_i & byte_sel[7]}}, byte_sel};
            end
            MM_HALF: begin
                wstrb_o = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{rdata2_i[15:0]}};
                load_o  = {{16{~read_us_i & half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the EX bundle, runs one data-memory transaction
// (req/gnt then rvalid), aligns load data and presents the MEM bundle to write-back.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [EX_DATA_W-1:0]  ex_data,
    input  logic                  ex_valid,
    output logic                  mem_ready,
    output logic                  dm_req,
    output logic                  dm_we,
    output logic [31:0]           dm_addr,
    output logic [3:0]            dm_wstrb,
    output logic [31:0]           dm_wdata,
    input  logic                  dm_gnt,
    input  logic                  dm_rvalid,
    input  logic [31:0]           dm_rdata,
    output logic [MEM_DATA_W-1:0] mem_data,
    output logic                  mem_valid,
    input  logic                  wb_ready,
    output logic [4:0]            mem_rd,
    output logic [31:0]           mem_fd_data,
    output logic                  mem_fd_valid,
    output logic                  mem_stall,
    output logic                  mem_misalign
);

    state_t      state_q, state_d;
    ex_data_t    ex_in, ex_q;
    logic [31:0] load_q;
    mem_data_t   md;

    logic        accept, capture;
    logic        in_access, accept_req;
    logic        held_access, held_misalign;
    logic        align_mis;
    logic [3:0]  align_wstrb;
    logic [31:0] align_wdata, align_load;

    assign ex_in = ex_data;

    // Ready is held low during reset so every output reads 0 while it is asserted.
    assign mem_ready  = ~reset & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & wb_ready));
    assign accept     = ex_valid & mem_ready;
    assign in_access  = ex_in.mem_read | ex_in.mem_write;
    assign accept_req = in_access & ~is_misaligned(ex_in.mem_mode, ex_in.result[1:0]);

    mem_align u_align (
        .mode_i     (ex_q.mem_mode),
        .off_i      (ex_q.result[1:0]),
        .read_us_i  (ex_q.mem_read_us),
        .rdata2_i   (ex_q.rdata2),
        .rdata_i    (dm_rdata),
        .wstrb_o    (align_wstrb),
        .wdata_o    (align_wdata),
        .load_o     (align_load),
        .misalign_o (align_mis)
    );

    assign held_access   = ex_q.mem_read | ex_q.mem_write;
    assign held_misalign = held_access & align_mis;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = accept_req ? ST_REQ : ST_DONE;
            end
            ST_REQ: begin
                if (dm_gnt & dm_rvalid) begin
                    state_d = ST_DONE;
                    capture = 1'b1;
                end else if (dm_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dm_rvalid) begin
                    state_d = ST_DONE;
                    capture = 1'b1;
                end
            end
            ST_DONE: begin
                if (accept)        state_d = accept_req ? ST_REQ : ST_DONE;
                else if (wb_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ex_q    <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ex_q   <= ex_in;
                load_q <= '0;
            end else if (capture & ex_q.mem_read) begin
                load_q <= align_load;
            end
        end
    end

    // Request fields are driven only while requesting; they are stable because ex_q only moves on accept.
    assign dm_req   = (state_q == ST_REQ);
    assign dm_we    = dm_req & ex_q.mem_write;
    assign dm_addr  = dm_req ? {ex_q.result[31:2], 2'b00} : 32'd0;
    assign dm_wstrb = dm_we ? align_wstrb : 4'd0;
    assign dm_wdata = dm_we ? align_wdata : 32'd0;

    always_comb begin
        md.reg_write  = ex_q.reg_write & ~held_misalign;
        md.memto_reg  = ex_q.memto_reg;
        md.rd         = ex_q.rd;
        md.alu_result = ex_q.result;
        md.load_data  = load_q;
    end

    assign mem_data     = md;
    assign mem_valid    = (state_q == ST_DONE);
    assign mem_rd       = ex_q.rd;
    assign mem_fd_data  = ex_q.mem_read ? load_q : ex_q.result;
    assign mem_fd_valid = mem_valid & md.reg_write;
    assign mem_stall    = (state_q == ST_REQ) | (state_q == ST_WAIT);
    assign mem_misalign = mem_valid & held_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized ops against an arithmetic reference model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [79:0] ex_data;
    logic        ex_valid;
    logic        mem_ready;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_wdata;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic [73:0] mem_data;
    logic        mem_valid, wb_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_fd_data;
    logic        mem_fd_valid, mem_stall, mem_misalign;

    int vectors = 0;
    int miscompares = 0;

    mem_stage dut (
        .clk(clk), .reset(reset), .ex_data(ex_data), .ex_valid(ex_valid), .mem_ready(mem_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .mem_data(mem_data),
        .mem_valid(mem_valid), .wb_ready(wb_ready), .mem_rd(mem_rd), .mem_fd_data(mem_fd_data),
        .mem_fd_valid(mem_fd_valid), .mem_stall(mem_stall), .mem_misalign(mem_misalign)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [79:0] mk_ex(input logic mw, input logic mr, input logic rw, input logic [3:0] mtr,
                                          input logic [2:0] mode, input logic us, input logic [31:0] rdata2,
                                          input logic [4:0] rd, input logic [31:0] result);
        return {mw, mr, rw, mtr, mode, us, rdata2, rd, result};
    endfunction

    function automatic logic m_mis(input logic [79:0] ex);
        int unsigned off;
        int unsigned mode;
        off  = ex[1:0];
        mode = ex[72:70];
        if (!(ex[79] || ex[78])) return 1'b0;
        if (mode == 1) return (off % 2) == 1;
        if (mode >= 2) return off != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [79:0] ex, input logic [31:0] w);
        int unsigned off, mode, v;
        off  = ex[1:0];
        mode = ex[72:70];
        if (mode == 0) begin
            v = (w >> (8 * off)) % 256;
            if (!ex[69] && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (mode == 1) begin
            v = (w >> (16 * (off / 2))) % 65536;
            if (!ex[69] && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [3:0] m_strb(input logic [79:0] ex);
        int unsigned off, mode;
        off  = ex[1:0];
        mode = ex[72:70];
        if (mode == 0) return 4'(1 << off);
        if (mode == 1) return (off >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [79:0] ex);
        int unsigned mode;
        logic [31:0] d;
        mode = ex[72:70];
        d    = ex[68:37];
        if (mode == 0) return {24'd0, d[7:0]} * 32'h0101_0101;
        if (mode == 1) return {16'd0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [73:0] m_md(input logic [79:0] ex, input logic [31:0] w);
        logic        rw;
        logic [31:0] ld;
        rw = ex[77] && !m_mis(ex);
        ld = (ex[78] && !m_mis(ex)) ? m_load(ex, w) : 32'd0;
        return {rw, ex[76:73], ex[36:32], ex[31:0], ld};
    endfunction

    function automatic int m_lat(input logic [79:0] ex, input int gd, input int rv, input bit same);
        if (!(ex[79] || ex[78]) || m_mis(ex)) return 0;
        return same ? gd + 1 : gd + rv + 2;
    endfunction

    // ---------------- driver: one op through the stage, returns observations ----------------
    task automatic do_op(input logic [79:0] ex, input int gd, input int rv, input bit same, input logic [31:0] rdata,
                         output int lat, output bit saw_req, output logic r_we, output logic [31:0] r_addr,
                         output logic [3:0] r_strb, output logic [31:0] r_wdata, output bit unstable,
                         output logic [73:0] md, output logic mis, output logic [31:0] fdd, output logic fdv,
                         output bit tmo);
        int g = 0;
        int r = 0;
        lat = 0; saw_req = 0; r_we = 0; r_addr = 0; r_strb = 0; r_wdata = 0; unstable = 0; tmo = 1;
        md = 0; mis = 0; fdd = 0; fdv = 0;
        ex_data = ex; ex_valid = 1'b1; wb_ready = 1'b0;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        ex_data  = {$urandom, $urandom, $urandom};
        for (int c = 0; c < 60; c++) begin
            if (mem_valid) begin
                tmo = 0;
                break;
            end
            lat++;
            if (dm_req) begin
                if (!saw_req) begin
                    saw_req = 1; r_we = dm_we; r_addr = dm_addr; r_strb = dm_wstrb; r_wdata = dm_wdata;
                end else if (dm_we !== r_we || dm_addr !== r_addr || dm_wstrb !== r_strb || dm_wdata !== r_wdata) begin
                    unstable = 1;
                end
                if (g == gd) begin
                    dm_gnt = 1'b1;
                    if (same) begin dm_rvalid = 1'b1; dm_rdata = rdata; end
                end else begin
                    g++;
                end
            end else if (mem_stall) begin
                if (r == rv) begin dm_rvalid = 1'b1; dm_rdata = rdata; end
                else r++;
            end
            @(posedge clk); #1;
            dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = $urandom;
        end
        md = mem_data; mis = mem_misalign; fdd = mem_fd_data; fdv = mem_fd_valid;
        wb_ready = 1'b1;
        @(posedge clk); #1;
        wb_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; ex_valid = 0; ex_data = 0; dm_gnt = 0; dm_rvalid = 0; dm_rdata = 0; wb_ready = 0;
        #1;
        vectors++;
        if ({mem_ready, dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata, mem_data, mem_valid, mem_rd, mem_fd_data,
             mem_fd_valid, mem_stall, mem_misalign} !== '0) begin
            miscompares++; $display("FAIL reset_outputs: some output nonzero during reset (mem_ready=%b mem_valid=%b)", mem_ready, mem_valid);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        vectors++;
        if (mem_ready !== 1'b1 || mem_valid !== 1'b0 || mem_stall !== 1'b0) begin
            miscompares++; $display("FAIL reset_idle: ready=%b valid=%b stall=%b, want 1 0 0", mem_ready, mem_valid, mem_stall);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        logic [79:0] ex; int lat; bit sr, us, tmo; logic we, mis, fdv; logic [31:0] a, wd, fdd; logic [3:0] st; logic [73:0] md;
        ex = mk_ex(0, 0, 1, 4'd0, 3'd2, 0, 32'hDEAD_BEEF, 5'd5, 32'h0000_1234);
        do_op(ex, 0, 0, 0, 32'd0, lat, sr, we, a, st, wd, us, md, mis, fdd, fdv, tmo);
        vectors++; if (tmo || lat !== 0) begin miscompares++; $display("FAIL alu_latency: got %0d timeout=%0d, want 0", lat, tmo); end
        vectors++; if (sr !== 1'b0) begin miscompares++; $display("FAIL alu_no_req: dm_req seen=%0d, want 0", sr); end
        vectors++; if (md !== 74'({1'b1, 4'd0, 5'd5, 32'h1234, 32'd0})) begin miscompares++; $display("FAIL alu_mem_data: got %h", md); end
        vectors++; if (fdv !== 1'b1 || fdd !== 32'h1234) begin miscompares++; $display("FAIL alu_forward: fd_valid=%b fd_data=%h, want 1 00001234", fdv, fdd); end
    endtask

    task automatic test_store();
        logic [79:0] ex; int lat; bit sr, us, tmo; logic we, mis, fdv; logic [31:0] a, wd, fdd; logic [3:0] st; logic [73:0] md;
        ex = mk_ex(1, 0, 0, 4'd0, 3'd0, 0, 32'h0000_00AB, 5'd0, 32'h0000_0103);
        do_op(ex, 2, 0, 0, 32'd0, lat, sr, we, a, st, wd, us, md, mis, fdd, fdv, tmo);
        vectors++; if (sr !== 1 || we !== 1 || a !== 32'h100) begin miscompares++; $display("FAIL store_req: req=%0d we=%b addr=%h, want 1 1 00000100", sr, we, a); end
        vectors++; if (st !== 4'b1000 || wd !== 32'hABAB_ABAB) begin miscompares++; $display("FAIL store_lanes: wstrb=%b wdata=%h, want 1000 abababab", st, wd); end
        vectors++; if (us !== 0) begin miscompares++; $display("FAIL store_stable: request fields changed before dm_gnt"); end
        vectors++; if (tmo || lat !== 4) begin miscompares++; $display("FAIL store_latency: got %0d timeout=%0d, want 4", lat, tmo); end
    endtask

    task automatic test_load();
        logic [79:0] ex; int lat; bit sr, us, tmo; logic we, mis, fdv; logic [31:0] a, wd, fdd; logic [3:0] st; logic [73:0] md;
        ex = mk_ex(0, 1, 1, 4'd1, 3'd0, 0, 32'd0, 5'd7, 32'h0000_0102);
        do_op(ex, 0, 1, 0, 32'h0080_FF00, lat, sr, we, a, st, wd, us, md, mis, fdd, fdv, tmo);
        vectors++; if (md[31:0] !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL load_byte_signed: got %h want ffffff80", md[31:0]); end
        vectors++; if (fdd !== 32'hFFFF_FF80 || fdv !== 1) begin miscompares++; $display("FAIL load_forward: fd_data=%h fd_valid=%b", fdd, fdv); end
        vectors++; if (we !== 0 || a !== 32'h100) begin miscompares++; $display("FAIL load_req: we=%b addr=%h want 0 00000100", we, a); end
        ex = mk_ex(0, 1, 1, 4'd1, 3'd0, 1, 32'd0, 5'd7, 32'h0000_0102);
        do_op(ex, 1, 0, 0, 32'h0080_FF00, lat, sr, we, a, st, wd, us, md, mis, fdd, fdv, tmo);
        vectors++; if (md[31:0] !== 32'h0000_0080) begin miscompares++; $display("FAIL load_byte_unsigned: got %h want 00000080", md[31:0]); end
        ex = mk_ex(0, 1, 1, 4'd1, 3'd1, 0, 32'd0, 5'd9, 32'h0000_0102);
        do_op(ex, 0, 0, 1, 32'h8001_0000, lat, sr, we, a, st, wd, us, md, mis, fdd, fdv, tmo);
        vectors++; if (md[31:0] !== 32'hFFFF_8001) begin miscompares++; $display("FAIL load_half_signed: got %h want ffff8001", md[31:0]); end
        vectors++; if (tmo || lat !== 1) begin miscompares++; $display("FAIL load_same_cycle_latency: got %0d want 1", lat); end
    endtask

    task automatic test_misalign();
        logic [79:0] ex; int lat; bit sr, us, tmo; logic we, mis, fdv; logic [31:0] a, wd, fdd; logic [3:0] st; logic [73:0] md;
        ex = mk_ex(0, 1, 1, 4'd1, 3'd2, 0, 32'd0, 5'd3, 32'h0000_0101);
        do_op(ex, 0, 0, 0, 32'd0, lat, sr, we, a, st, wd, us, md, mis, fdd, fdv, tmo);
        vectors++; if (sr !== 0 || lat !== 0) begin miscompares++; $display("FAIL misalign_no_req: req=%0d lat=%0d want 0 0", sr, lat); end
        vectors++; if (mis !== 1) begin miscompares++; $display("FAIL misalign_flag: got %b want 1", mis); end
        vectors++; if (md[73] !== 0 || fdv !== 0) begin miscompares++; $display("FAIL misalign_regwrite: RegWrite=%b fd_valid=%b want 0 0", md[73], fdv); end
    endtask

    task automatic test_backpressure();
        logic [79:0] ex; logic [73:0] exp;
        ex  = mk_ex(0, 0, 1, 4'd2, 3'd2, 0, 32'd0, 5'd11, $urandom);
        exp = m_md(ex, 32'd0);
        ex_data = ex; ex_valid = 1; wb_ready = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            ex_data = {$urandom, $urandom, $urandom};
            #1;
            vectors++;
            if (mem_ready !== 0 || mem_valid !== 1 || mem_data !== exp) begin
                miscompares++; $display("FAIL hold_done[%0d]: ready=%b valid=%b data=%h want 0 1 %h", i, mem_ready, mem_valid, mem_data, exp);
            end
            @(posedge clk); #1;
        end
        ex_valid = 0; wb_ready = 1;
        #1;
        vectors++; if (mem_ready !== 1) begin miscompares++; $display("FAIL release_ready: got %b want 1", mem_ready); end
        @(posedge clk); #1;
        wb_ready = 0;
        vectors++; if (mem_valid !== 0) begin miscompares++; $display("FAIL release_idle: mem_valid=%b want 0", mem_valid); end
    endtask

    task automatic test_reset_in_wait();
        ex_data = mk_ex(0, 1, 1, 4'd1, 3'd2, 0, 32'd0, 5'd4, 32'h0000_0040);
        ex_valid = 1;
        @(posedge clk); #1;
        ex_valid = 0; dm_gnt = 1;
        @(posedge clk); #1;
        dm_gnt = 0;
        vectors++; if (mem_stall !== 1 || dm_req !== 0) begin miscompares++; $display("FAIL wait_state: stall=%b req=%b want 1 0", mem_stall, dm_req); end
        reset = 1;
        #1;
        vectors++;
        if ({mem_ready, dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata, mem_data, mem_valid, mem_rd, mem_fd_data,
             mem_fd_valid, mem_stall, mem_misalign} !== '0) begin
            miscompares++; $display("FAIL reset_in_wait: outputs nonzero, stall=%b rd=%h", mem_stall, mem_rd);
        end
        @(posedge clk); #1;
        reset = 0; dm_rvalid = 1; dm_rdata = $urandom;
        @(posedge clk); #1;
        dm_rvalid = 0;
        vectors++;
        if (mem_valid !== 0 || mem_stall !== 0 || mem_ready !== 1) begin
            miscompares++; $display("FAIL late_rvalid: valid=%b stall=%b ready=%b want 0 0 1", mem_valid, mem_stall, mem_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [79:0] ex, prev;
        prev = 0;
        wb_ready = 1; ex_valid = 1;
        for (int i = 0; i < 8; i++) begin
            ex = mk_ex(0, 0, 1'($urandom), 4'($urandom), 3'd2, 0, $urandom, 5'($urandom), $urandom);
            ex_data = ex;
            #1;
            vectors++;
            if (mem_ready !== 1 || (i > 0 && (mem_valid !== 1 || mem_data !== m_md(prev, 32'd0)))) begin
                miscompares++; $display("FAIL b2b[%0d]: ready=%b valid=%b data=%h", i, mem_ready, mem_valid, mem_data);
            end
            prev = ex;
            @(posedge clk); #1;
        end
        ex_valid = 0;
        vectors++; if (mem_valid !== 1 || mem_data !== m_md(prev, 32'd0)) begin miscompares++; $display("FAIL b2b_last: valid=%b data=%h", mem_valid, mem_data); end
        @(posedge clk); #1;
        wb_ready = 0;
        vectors++; if (mem_valid !== 0) begin miscompares++; $display("FAIL b2b_drain: mem_valid=%b want 0", mem_valid); end
    endtask

    task automatic test_random();
        logic [79:0] ex; int lat, gd, rv, kind; bit sr, us, tmo, same; logic we, mis, fdv;
        logic [31:0] a, wd, fdd, w; logic [3:0] st; logic [73:0] md; bit acc;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            ex = mk_ex(kind == 2, kind == 1, 1'($urandom), 4'($urandom), 3'($urandom_range(0, 3)), 1'($urandom),
                       $urandom, 5'($urandom), $urandom);
            gd = $urandom_range(0, 3); rv = $urandom_range(0, 3); same = 1'($urandom); w = $urandom;
            acc = (kind != 0) && !m_mis(ex);
            do_op(ex, gd, rv, same, w, lat, sr, we, a, st, wd, us, md, mis, fdd, fdv, tmo);
            vectors++;
            if (tmo || lat !== m_lat(ex, gd, rv, same) || sr !== acc) begin
                miscompares++; $display("FAIL rnd%0d_timing: lat=%0d req=%0d want %0d %0d", n, lat, sr, m_lat(ex, gd, rv, same), acc);
            end
            vectors++;
            if (md !== m_md(ex, w) || mis !== m_mis(ex)) begin
                miscompares++; $display("FAIL rnd%0d_mem_data: got %h mis=%b want %h mis=%b", n, md, mis, m_md(ex, w), m_mis(ex));
            end
            vectors++;
            if (fdd !== (ex[78] ? m_md(ex, w)[31:0] : ex[31:0]) || fdv !== m_md(ex, w)[73]) begin
                miscompares++; $display("FAIL rnd%0d_forward: fd_data=%h fd_valid=%b", n, fdd, fdv);
            end
            if (acc) begin
                vectors++;
                if (a !== {ex[31:2], 2'b00} || we !== ex[79] || us !== 0 ||
                    (ex[79] && (st !== m_strb(ex) || wd !== m_wdata(ex)))) begin
                    miscompares++; $display("FAIL rnd%0d_request: addr=%h we=%b strb=%b wdata=%h unstable=%0d want %h %b %b %h",
                                            n, a, we, st, wd, us, {ex[31:2], 2'b00}, ex[79], m_strb(ex), m_wdata(ex));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_load();
        test_misalign();
        test_backpressure();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
